// File: rtl/x_lin_write_sequencer_pkg.sv
// x_lin_write_sequencer_pkg: constants and state type shared by the write sequencer and the channel register bank
package x_lin_write_sequencer_pkg;
   localparam int NUM_CH = 32;
   localparam int DATA_W = 21;
   localparam int IDX_W  = 5;
   typedef enum logic {IDLE, LOAD} state_t;
endpackage

// File: rtl/x_lin_write_sequencer_ch_onehot_decode.sv
// x_lin_write_sequencer_ch_onehot_decode: gated IDX_W-to-NUM_CH one-hot decoder (i_idx, i_valid -> o_onehot)
module x_lin_write_sequencer_ch_onehot_decode
   import x_lin_write_sequencer_pkg::*;
(
   input  logic [IDX_W-1:0]  i_idx,
   input  logic              i_valid,
   output logic [NUM_CH-1:0] o_onehot
);
   always_comb o_onehot = i_valid ? ({{(NUM_CH-1){1'b0}}, 1'b1} << i_idx) : '0;
endmodule

// File: rtl/x_lin_write_sequencer.sv
// x_lin_write_sequencer: maps framed samples onto one-hot channel enables (clk, GlobalReset, frame_start, in_valid, in_data -> enable, out_data, ch_idx, busy, frame_done, frame_err)
module x_lin_write_sequencer
   import x_lin_write_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              GlobalReset,
   input  logic              frame_start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0] enable,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  ch_idx,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);
   state_t            r_state, w_next;
   logic [IDX_W-1:0]  r_cnt, w_cnt_next, w_idx;
   logic              w_start, w_issue, w_done, w_err;
   logic [NUM_CH-1:0] w_onehot;
   assign w_start = in_valid & frame_start;
   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end
   // A frame_start accepted in LOAD restarts at channel 0, so the counter reloads to 1 like a fresh start.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      if (r_state == IDLE) begin
         if (w_start) begin
            w_next     = LOAD;
            w_cnt_next = IDX_W'(1);
         end
      end else if (in_valid) begin
         if (frame_start) begin
            w_cnt_next = IDX_W'(1);
         end else if (r_cnt == LAST) begin
            w_next     = IDLE;
            w_cnt_next = '0;
         end else begin
            w_cnt_next = r_cnt + IDX_W'(1);
         end
      end
   end
   // Unframed samples in IDLE are not issued; any frame_start restarts at channel 0.
   always_comb begin
      w_issue = in_valid & (frame_start | (r_state == LOAD));
      w_idx   = (frame_start | (r_state == IDLE)) ? '0 : r_cnt;
      w_done  = (r_state == LOAD) & in_valid & ~frame_start & (r_cnt == LAST);
      w_err   = (r_state == LOAD) & w_start;
   end
   x_lin_write_sequencer_ch_onehot_decode u_dec (
      .i_idx    (w_idx),
      .i_valid  (w_issue),
      .o_onehot (w_onehot)
   );
   // busy stays high through the cycle that presents the last channel.
   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         enable     <= '0;
         out_data   <= '0;
         ch_idx     <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         enable     <= w_onehot;
         out_data   <= w_issue ? in_data : '0;
         ch_idx     <= w_issue ? w_idx : '0;
         busy       <= (w_next == LOAD) | w_done;
         frame_done <= w_done;
         frame_err  <= w_err;
      end
   end
endmodule
